// File: rtl/loader_pkg.sv
// Shared types and helpers for the boot-time instruction loader.
// LOADER_CHECKSUM_EN (consumed by instr_loader) enables the trailing checksum word.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Little-endian lane shift: the newest byte enters at [31:24], so after four
  // shifts the first byte sits in [7:0].
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  new_byte);
    return {new_byte, word[31:8]};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes into a 32-bit little-endian word; complete_o marks the
// fourth byte of each group, with word_o already including that byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        complete_o
);

  logic [31:0] shift_r;
  logic [1:0]  lane_r;

  // Byte shift register and lane counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_r <= 32'd0;
      lane_r  <= 2'd0;
    end else if (clear_i) begin
      shift_r <= 32'd0;
      lane_r  <= 2'd0;
    end else if (shift_i) begin
      shift_r <= shift_in_byte(shift_r, byte_i);
      lane_r  <= lane_r + 2'd1;
    end else begin
      shift_r <= shift_r;
      lane_r  <= lane_r;
    end
  end

  assign word_o     = shift_in_byte(shift_r, byte_i);
  assign complete_o = shift_i && (lane_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Boot loader: length header, payload words written from BASE_ADDR, CPU held until done.
// Optional trailing XOR checksum word when LOADER_CHECKSUM_EN is defined.
module instr_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic        restart_i,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int K_W = $clog2(MAX_WORDS + 1);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t PAYLOAD_NEXT = CSUM;
`else
  localparam loader_state_t PAYLOAD_NEXT = DONE;
`endif

  loader_state_t  state_r, next_state_s;
  logic           xfer_s, restart_s, complete_s, last_word_s, release_s;
  logic [31:0]    word_s, count_r;
  logic [K_W-1:0] k_r;
  logic           ready_r, wr_en_r, hold_r, done_r, err_r;
  logic [31:0]    wr_addr_r, wr_data_r;
  logic           csum_ok_s;

  assign xfer_s      = byte_valid_i && ready_r;
  assign restart_s   = restart_i && ((state_r == DONE) || (state_r == ERR));
  assign last_word_s = ((32'(k_r) + 32'd1) == count_r);

  word_assembler u_asm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (restart_s),
    .shift_i    (xfer_s),
    .byte_i     (byte_data_i),
    .word_o     (word_s),
    .complete_o (complete_s)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_r;

  // XOR accumulator over payload words
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum_r <= 32'd0;
    end else if (restart_s) begin
      csum_r <= 32'd0;
    end else if ((state_r == DATA) && complete_s) begin
      csum_r <= csum_r ^ word_s;
    end else begin
      csum_r <= csum_r;
    end
  end

  assign csum_ok_s = (word_s == csum_r);
`else
  assign csum_ok_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= LEN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LEN: begin
        if (!complete_s) begin
          next_state_s = LEN;
        end else if (word_s == 32'd0) begin
          next_state_s = PAYLOAD_NEXT;
        end else if (word_s > 32'(MAX_WORDS)) begin
          next_state_s = ERR;
        end else begin
          next_state_s = DATA;
        end
      end
      DATA: begin
        if (complete_s && last_word_s) begin
          next_state_s = PAYLOAD_NEXT;
        end else begin
          next_state_s = DATA;
        end
      end
      CSUM: begin
        if (!complete_s) begin
          next_state_s = CSUM;
        end else if (csum_ok_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ERR;
        end
      end
      DONE, ERR: begin
        if (restart_s) begin
          next_state_s = LEN;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ERR;
    endcase
  end

  // Leaving DATA straight into DONE delays the release one cycle so it follows the final write.
  assign release_s = (next_state_s == DONE) && (state_r != DATA);

  // Counters, write port and registered status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r   <= 32'd0;
      k_r       <= '0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 32'd0;
      wr_data_r <= 32'd0;
      ready_r   <= 1'b1;
      hold_r    <= 1'b1;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      if (restart_s) begin
        count_r <= 32'd0;
        k_r     <= '0;
      end else if (complete_s && (state_r == LEN)) begin
        count_r <= word_s;
      end else if (complete_s && (state_r == DATA)) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= BASE_ADDR + (32'(k_r) * 32'd4);
        wr_data_r <= word_s;
        k_r       <= k_r + K_W'(1);
      end else begin
        count_r <= count_r;
        k_r     <= k_r;
      end
      ready_r <= (next_state_s == LEN) || (next_state_s == DATA) || (next_state_s == CSUM);
      err_r   <= (next_state_s == ERR);
      done_r  <= release_s;
      hold_r  <= !release_s;
    end
  end

  assign byte_ready_o = ready_r;
  assign wr_en_o      = wr_en_r;
  assign wr_addr_o    = wr_addr_r;
  assign wr_data_o    = wr_data_r;
  assign cpu_hold_o   = hold_r;
  assign done_o       = done_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of image loads plus hand sequences
// for mid-load reset and restart; writes are checked against a scoreboard queue.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam int          MAXW = 1024;

  logic        clk, rst;
  logic        byte_valid, byte_ready, restart;
  logic [7:0]  byte_data;
  logic        wr_en, cpu_hold, done, err;
  logic [31:0] wr_addr, wr_data;

  instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .restart_i    (restart),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .cpu_hold_o   (cpu_hold),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] step;
    int          gap;
    bit          bad;
    bit          exp_err;
    bit          lag;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] n, input logic [31:0] w0,
                              input logic [31:0] step, input int gap, input bit bad);
    vec_t v;
    v.n    = n;
    v.w0   = w0;
    v.step = step;
    v.gap  = gap;
    v.bad  = bad;
`ifdef LOADER_CHECKSUM_EN
    v.exp_err = (n > 32'(MAXW)) || bad;
    v.lag     = 1'b0;
`else
    v.exp_err = (n > 32'(MAXW));
    v.lag     = !v.exp_err && (n != 32'd0);
`endif
    return v;
  endfunction

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk) begin : wr_monitor
    wr_t e;
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check32("wr_addr", wr_addr, e.addr);
        check32("wr_data", wr_data, e.data);
        check1("hold_during_write", cpu_hold, 1'b1);
      end
    end
  end

  // Called and returns at posedge+1
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    byte_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    budget     = 0;
    while (!byte_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!byte_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL byte_accept_timeout: got ready 0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(tmp[7:0], int'($urandom_range(gap_max, 0)));
      tmp = tmp >> 8;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_ready"}, byte_ready, 1'b1);
    check1({tag, "_wr_en"}, wr_en, 1'b0);
    check32({tag, "_wr_addr"}, wr_addr, 32'd0);
    check32({tag, "_wr_data"}, wr_data, 32'd0);
    check1({tag, "_hold"}, cpu_hold, 1'b1);
    check1({tag, "_done"}, done, 1'b0);
    check1({tag, "_err"}, err, 1'b0);
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] acc, w;
    acc = 32'd0;
    send_word(v.n, v.gap);
    if (v.n <= 32'(MAXW)) begin
      for (int i = 0; i < int'(v.n); i++) begin
        w   = v.w0 + v.step * 32'(i);
        acc = acc ^ w;
        exp_q.push_back('{addr: BASE + 32'(i) * 32'd4, data: w});
        send_word(w, v.gap);
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(acc + 32'(v.bad), v.gap);
`endif
    end
    if (v.exp_err) begin
      check1("err_flag", err, 1'b1);
      check1("err_ready", byte_ready, 1'b0);
      check1("err_hold", cpu_hold, 1'b1);
      check1("err_done", done, 1'b0);
    end else begin
      if (v.lag) begin
        check1("last_write_strobe", wr_en, 1'b1);
        check1("done_before_release", done, 1'b0);
        check1("hold_before_release", cpu_hold, 1'b1);
        @(posedge clk); #1;
        check1("strobe_one_cycle", wr_en, 1'b0);
      end
      check1("done_flag", done, 1'b1);
      check1("release_hold", cpu_hold, 1'b0);
      check1("done_err", err, 1'b0);
      check1("done_ready", byte_ready, 1'b0);
    end
    @(posedge clk); #1;
    check32("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    check1("restart_hold", cpu_hold, 1'b1);
    check1("restart_done", done, 1'b0);
    check1("restart_err", err, 1'b0);
    check1("restart_ready", byte_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = mk(32'd1, 32'h0010_0513, 32'd0, 0, 1'b0);
    vecs[1] = mk(32'd3, 32'h1234_5678, 32'h0F0F_0F0F, 3, 1'b0);
    vecs[2] = mk(32'd0, 32'd0, 32'd0, 2, 1'b0);
    vecs[3] = mk(32'h0000_0401, 32'd0, 32'd0, 0, 1'b0);
    vecs[4] = mk(32'd2, 32'h1111_1111, 32'h1111_1111, 1, 1'b0);
    vecs[5] = mk(32'd2, 32'h1111_1111, 32'h1111_1111, 0, 1'b1);
    vecs[6] = mk(32'd1024, 32'hA500_0000, 32'd1, 0, 1'b0);

    rst        = 1'b1;
    restart    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_load(vecs[i]);
      do_restart();
    end

    // Reset after six payload bytes: one word written, second word abandoned
    send_word(32'd2, 0);
    exp_q.push_back('{addr: BASE, data: 32'hCAFE_F00D});
    send_word(32'hCAFE_F00D, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    rst = 1'b1;
    #2;
    check_reset_outputs("midload_reset");
    check32("midload_writes", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_load(vecs[1]);

    // In DONE: restart together with a valid byte; the byte must not be consumed
    restart    = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    check1("ready_in_done", byte_ready, 1'b0);
    @(posedge clk); #1;
    restart    = 1'b0;
    byte_valid = 1'b0;
    check1("rearm_hold", cpu_hold, 1'b1);
    check1("rearm_done", done, 1'b0);
    check1("rearm_ready", byte_ready, 1'b1);

    // Restart outside DONE/ERR is ignored
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    check1("restart_ignored_ready", byte_ready, 1'b1);
    check1("restart_ignored_hold", cpu_hold, 1'b1);
    run_load(mk(32'd1, 32'hAABB_CCDD, 32'd0, 1, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader: the write side of the instruction memory that the fetch/decode path reads. It accepts a little-endian byte stream (length header, payload, optional checksum). It assembles 32-bit instruction words and writes them to consecutive instruction-memory addresses starting at BASE_ADDR. It holds the CPU in stall until the image is fully written, and can be re-armed to load a new image without a global reset.

## Interface
- BASE_ADDR, 32'hBFC0_0000, byte address of the first instruction word
- MAX_WORDS, 1024, largest accepted word count; must be ≥1
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- byte_valid_i  input  1  stream byte valid
- byte_data_i  input  8  stream byte
- byte_ready_o  output  1  loader can accept a byte
- restart_i  input  1  re-arm loader; honoured only in DONE or ERR
- wr_en_o  output  1  instruction-memory write strobe, one cycle per word
- wr_addr_o  output  32  write byte address, word aligned
- wr_data_o  output  32  instruction word
- cpu_hold_o  output  1  stall CPU / hold PC at reset vector
- done_o  output  1  image loaded successfully
- err_o  output  1  length or checksum failure

## Operation
- Handshake: byte transferred on rising edge where byte_valid_i & byte_ready_o. byte_ready_o = 1 in LEN, DATA, CSUM; 0 elsewhere. byte_data_i may change freely when not transferred.
- Byte order: within every 4-byte group, the first byte is bits [7:0] and the fourth byte is bits [31:24].
- States: LEN → DATA → (CSUM) → DONE; any failure → ERR.
- LEN: collect 4 bytes into word count N.
  - If N = 0: go to CSUM if enabled, else DONE.
  - If N > MAX_WORDS: go to ERR.
  - Otherwise: go to DATA with word index k = 0.
- DATA: each 4th byte completes word k.
  - Next cycle: wr_en_o = 1, wr_addr_o = BASE_ADDR + 4k, wr_data_o = word.
  - k increments.
  - After word N−1: go to CSUM if enabled, else DONE.
- DONE: cpu_hold_o = 0, done_o = 1.
- ERR: cpu_hold_o = 1, err_o = 1.
- restart_i in DONE or ERR: go to LEN. Clears the byte counter, k, the checksum accumulator and the flags, and sets cpu_hold_o = 1. Ignored in other states.
- Address arithmetic: 32-bit with wrap-around; no overflow detection. The k counter is wide enough for MAX_WORDS.

## Timing
- Reset values: state LEN; byte_ready_o 1, wr_en_o 0, wr_addr_o 0, wr_data_o 0, cpu_hold_o 1, done_o 0, err_o 0. All counters 0.
- Reset asserted mid-load aborts immediately. Partially written memory is not cleared.
- wr_en_o rises exactly one cycle after the 4th-byte handshake edge and is high for one cycle. wr_addr_o and wr_data_o hold their values until the next write.
- Back-to-back bytes, one per cycle, are accepted with no bubbles. Minimum spacing between writes is 4 cycles.
- Hold release is ordered after the final write:
  - done_o rises and cpu_hold_o falls one cycle after the final wr_en_o pulse.
  - If N = 0 without checksum, this happens one cycle after the last LEN byte.
  - With checksum, it happens one cycle after the last CSUM byte.
- ERR is entered on the edge of the offending byte's handshake. err_o is visible the next cycle.
- restart_i and byte_valid_i together in DONE: restart wins. No byte is accepted that cycle because byte_ready_o is 0.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Accumulator = XOR of all N payload words; 0 when N = 0.
  - After the payload, a CSUM state collects 4 bytes, little-endian.
  - Match → DONE; mismatch → ERR.
- LOADER_CHECKSUM_EN undefined: no CSUM state and no accumulator; DATA goes directly to DONE.

## Structure
- Package loader_pkg holds:
  - loader_state_t enum {LEN, DATA, CSUM, DONE, ERR}
  - BYTES_PER_WORD = 4
  - the byte-lane shift helper
- Sub-module word_assembler: shifts bytes into a 32-bit register with a 2-bit lane counter and flags word_complete. It is reused for LEN, DATA and CSUM.

## Test plan
- Stream 01 00 00 00, 13 05 10 00 → one write at BFC00000 of 00100513. done_o = 1 two cycles after the last byte.
- N = 3, bytes sent with random valid gaps → writes to BFC00000/04/08 with the correct words. cpu_hold_o stays 1 until the cycle after the third write.
- N = 0x00000401 with MAX_WORDS = 1024 → ERR after the 4th header byte, no wr_en_o, cpu_hold_o = 1, byte_ready_o = 0.
- LOADER_CHECKSUM_EN: N = 2 with words 11111111 and 22222222, checksum 33333333 → DONE. Checksum 33333334 → ERR.
- Assert rst_i after 6 payload bytes → all outputs at reset values. A full reload then succeeds.
- In DONE, pulse restart_i and reload N = 1 word AABBCCDD → cpu_hold_o reasserts, a write lands at BFC00000, and done_o rises again.
